// File: rtl/kpg_pkg.sv
// Shared kpg carry-character encoding and sequencer state encoding for the
// serial kpg arithmetic datapath.
package kpg_pkg;

  localparam logic [7:0] KPG_K = 8'h6B;  // kill: carry 0 (borrow in subtract)
  localparam logic [7:0] KPG_P = 8'h70;  // propagate: inherit previous char
  localparam logic [7:0] KPG_G = 8'h67;  // generate: carry 1 (no borrow)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/kpg_sub_slice.sv
// Combinational SLICE-bit subtract slice: a + ~b + carry, with the carry held
// as a kpg character. The incoming char is always resolved ("k" or "g"), so
// the prefix resolve below never leaves a "p" on the carry-out.
module kpg_sub_slice
  import kpg_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [7:0]       cin,
  output logic [SLICE-1:0] d,
  output logic [7:0]       cout
);

  logic [7:0]       chr;
  logic [SLICE-1:0] nb;

  assign nb = ~b;

  // Ripple the resolved kpg char through the slice, LSB first.
  always_comb begin
    d   = '0;
    chr = cin;
    for (int i = 0; i < SLICE; i++) begin
      d[i] = a[i] ^ nb[i] ^ (chr == KPG_G);
      if (a[i] && nb[i])
        chr = KPG_G;
      else if (!a[i] && !nb[i])
        chr = KPG_K;
    end
    cout = chr;
  end

endmodule

// File: rtl/serial_kpg_subtractor.sv
// Serial subtractor: diff = a - b - borrow_in, one SLICE-bit slice per clock,
// LSB slice first. The final kpg carry char is exported on xout so results
// chain into other stages using the same carry convention.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | one slice per edge, cnt selects the slice
//   DONE  | single cycle with done=1, result valid
module serial_kpg_subtractor
  import kpg_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       xin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic [7:0]       xout,
  output logic             borrow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [7:0]       carry;
  logic [SLICE-1:0] s_a, s_b, s_d;
  logic [7:0]       s_cout;
  logic             last;

  assign s_a    = a_q[cnt*SLICE +: SLICE];
  assign s_b    = b_q[cnt*SLICE +: SLICE];
  assign last   = (cnt == CW'(NSLICE - 1));
  assign busy   = (state == RUN) || (state == DONE);
  assign borrow = (xout == KPG_K);

  kpg_sub_slice #(.SLICE(SLICE)) u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry),
    .d    (s_d),
    .cout (s_cout)
  );

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture, slice walk and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= KPG_G;
      diff  <= '0;
      xout  <= KPG_G;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            // Anything other than "k" is treated as no borrow-in.
            carry <= (xin == KPG_K) ? KPG_K : KPG_G;
            diff  <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          diff[cnt*SLICE +: SLICE] <= s_d;
          carry                    <= s_cout;
          if (last) begin
            done <= 1'b1;
            xout <= s_cout;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_kpg_subtractor.sv
// Bench for serial_kpg_subtractor: directed vector table, randomized ops
// against a plain-arithmetic model, plus ignored-start and mid-run reset
// sequences.
module tb_serial_kpg_subtractor;

  localparam logic [7:0] CK = 8'h6B;
  localparam logic [7:0] CG = 8'h67;
  localparam int NS = 8;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] a, b;
  logic [7:0]  xin;
  logic        busy, done, borrow;
  logic [63:0] diff;
  logic [7:0]  xout;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  serial_kpg_subtractor #(.WIDTH(64), .SLICE(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .xin    (xin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .xout   (xout),
    .borrow (borrow)
  );

  typedef struct {
    logic [63:0] va;
    logic [63:0] vb;
    logic [7:0]  vx;
    logic [63:0] ed;
    logic [7:0]  ex;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: full-precision subtraction; bit 64 of the result is the borrow.
  task automatic model(input logic [63:0] va, input logic [63:0] vb, input logic [7:0] vx,
                       output logic [63:0] ed, output logic [7:0] ex);
    logic [64:0] f;
    f  = {1'b0, va} - {1'b0, vb} - ((vx == CK) ? 65'd1 : 65'd0);
    ed = f[63:0];
    ex = f[64] ? CK : CG;
  endtask

  task automatic run_and_check(input string nm, input logic [63:0] va, input logic [63:0] vb,
                               input logic [7:0] vx, input logic [63:0] ed, input logic [7:0] ex);
    int cyc;
    bit got;
    @(negedge clk);
    a = va; b = vb; xin = vx; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; xin = 8'($urandom);
    check({nm, "_busy"}, 64'(busy), 64'd1);
    cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1;
    end
    check({nm, "_lat"}, 64'(cyc), 64'(NS));
    check({nm, "_diff"}, diff, ed);
    check({nm, "_xout"}, 64'(xout), 64'(ex));
    check({nm, "_borrow"}, 64'(borrow), 64'(ex == CK));
    @(posedge clk); #1;
    check({nm, "_donelow"}, {62'd0, done, busy}, 64'd0);
    check({nm, "_hold"}, diff, ed);
  endtask

  initial begin
    logic [63:0] ra, rb, ed, first_diff;
    logic [7:0]  rx, ex;
    int ndone;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; xin = '0;
    #12;
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_done",   64'(done),   64'd0);
    check("rst_diff",   diff,        64'd0);
    check("rst_xout",   64'(xout),   64'(CG));
    check("rst_borrow", 64'(borrow), 64'd0);
    @(negedge clk); rst = 1'b0;

    tbl[0] = '{64'd100, 64'd1, CG, 64'd99, CG};
    tbl[1] = '{64'd0, 64'd1, CG, 64'hFFFF_FFFF_FFFF_FFFF, CK};
    tbl[2] = '{64'd5, 64'd3, CK, 64'd1, CG};
    tbl[3] = '{64'd5, 64'd3, 8'h00, 64'd2, CG};
    tbl[4] = '{64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, CG, 64'd0, CG};
    tbl[5] = '{64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, CK, 64'hFFFF_FFFF_FFFF_FFFF, CK};
    tbl[6] = '{64'd0, 64'd0, CK, 64'hFFFF_FFFF_FFFF_FFFF, CK};
    tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'h70, 64'hFFFF_FFFF_FFFF_FFFF, CG};

    for (int i = 0; i < 8; i++)
      run_and_check($sformatf("vec%0d", i), tbl[i].va, tbl[i].vb, tbl[i].vx, tbl[i].ed, tbl[i].ex);

    for (int i = 0; i < 30; i++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 5) == 0) ? ra : {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0:       rx = CK;
        1:       rx = CG;
        default: rx = 8'($urandom);
      endcase
      model(ra, rb, rx, ed, ex);
      run_and_check($sformatf("rnd%0d", i), ra, rb, rx, ed, ex);
    end

    // Start pulsed again right after acceptance must be ignored.
    @(negedge clk);
    a = 64'd1000; b = 64'd1; xin = CG; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    a = 64'd5; b = 64'd9; xin = CK; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first_diff = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        first_diff = diff;
      end
    end
    check("ign_ndone", 64'(ndone), 64'd1);
    check("ign_diff", first_diff, 64'd999);
    check("ign_xout", 64'(xout), 64'(CG));

    // Reset during slice 3 aborts with no done pulse.
    @(negedge clk);
    a = 64'd77; b = 64'd7; xin = CG; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_diff", diff, 64'd0);
    check("abort_xout", 64'(xout), 64'(CG));
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("abort_nodone", 64'(ndone), 64'd0);
    run_and_check("post_rst", 64'd77, 64'd7, CG, 64'd70, CG);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/serial_kpg_subtractor.md
Name: serial_kpg_subtractor

Overview:
Multi-cycle subtractor computing diff = a - b - borrow_in over WIDTH bits, one SLICE-bit slice per clock, LSB slice first.
Carries between slices are held as kpg status characters, same ASCII encoding as the adder datapath: "k"=8'h6B, "p"=8'h70, "g"=8'h67.
The final kpg character is exported as xout, so results chain into adder/subtractor stages built on the same carry convention.
Used where operands wider than one combinational adder are needed and area matters more than latency.

Parameters:
WIDTH, 64, operand/result width in bits; must be a multiple of SLICE
SLICE, 8, bits processed per cycle
NSLICE, WIDTH/SLICE, derived slice count (localparam)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
xin  input  8  kpg carry-in char; "k" = borrow-in, any other value = no borrow-in ("g")
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result valid
diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH
xout  output  8  final carry char; always "g" (no borrow) or "k" (borrow)
borrow  output  1  (xout == "k")

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, busy=0, done=0, diff=0, xout="g", borrow=0, operand registers=0.
- Subtraction is performed as a + ~b + cin, with the carry state kept as a kpg char: cin char = "g" when there is no borrow-in and "k" when xin=="k".
- Per-slice kpg: bit k if a_i=0 and ~b_i=0; g if both are 1; p otherwise. Apply a prefix resolve with the incoming char: p inherits the previous resolved char. Sum bit = a_i ^ ~b_i ^ (resolved_prev=="g").
- The slice carry-out char is the resolved char of the slice MSB, so it is never "p".
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: on start=1, capture a, b and normalized xin into the carry register. Clear diff to 0, set cnt=0, go to RUN.
  - RUN: each edge writes diff[cnt*SLICE +: SLICE] and updates the carry register. On the edge for cnt==NSLICE-1, go to DONE, set done=1 and update xout/borrow.
  - DONE: exactly one cycle; next edge clears done and returns to IDLE.
- Latency: start sampled at edge E0 gives done=1 in the cycle after edge E(NSLICE), i.e. NSLICE cycles. The next start can be accepted in the cycle after done.
- start in RUN or DONE is ignored; there is no queuing. a, b and xin may change freely after capture.
- diff, xout and borrow hold their values until the next accepted start. diff is partially updated during RUN and is meaningful only when done=1 or later.
- xout/borrow change only on the DONE transition, not on each slice.
- Reset asserted mid-operation aborts immediately to the reset values. No partial result and no done pulse are produced.
- Equal operands with no borrow-in: every bit is p, the chain resolves to cin "g", giving diff=0 and xout="g".

Decomposition:
- Package kpg_pkg: localparams KPG_K, KPG_P, KPG_G (8-bit chars) and the FSM state encoding (IDLE, RUN, DONE).
- Sub-module kpg_sub_slice: combinational, SLICE-bit. Inputs: a slice, b slice, 8-bit carry-in char. Outputs: SLICE diff bits and resolved carry-out char.
- Top level holds the FSM, slice counter, operand registers and output registers only.

Test Plan:
- a=100, b=1, xin="g" -> done after 8 cycles; diff=99, xout="g", borrow=0.
- a=0, b=1, xin="g" -> diff=64'hFFFF_FFFF_FFFF_FFFF, xout="k", borrow=1.
- a=5, b=3, xin="k" -> diff=1, borrow=0. Repeat with xin=8'h00: diff=2, xout="g" (invalid char treated as no borrow).
- a=b=64'hDEAD_BEEF_0123_4567, xin="g" -> diff=0, xout="g". Then a=b, xin="k" -> diff=all ones, xout="k".
- Pulse start again on the cycle after the first accepted start, with different operands -> ignored; the first result completes unchanged and done pulses exactly once.
- Assert rst for 1 cycle at slice 3 of a RUN -> busy=0, done=0, diff=0, xout="g" immediately. No done pulse follows; a new start then completes normally.
